// File: rtl/mini_cpu_pkg.sv
// Shared mini CPU definitions: datapath widths, register count and the opcode set
// used by decode and execute.
package mini_cpu_pkg;

  localparam int DW       = 8;
  localparam int AW       = 2;
  localparam int OPW      = 4;
  localparam int NUM_REGS = 4;

  typedef enum logic [OPW-1:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_AND = 4'h3,
    OP_OR  = 4'h4,
    OP_XOR = 4'h5,
    OP_MOV = 4'h6,
    OP_LDI = 4'h7
  } opcode_e;

endpackage

// File: rtl/mini_operand_fetch_if.sv
// Bundle between the operand-fetch stage and its neighbours: decode handshake,
// regfile read/write ports and the issue slot toward execute.
interface mini_operand_fetch_if;
  import mini_cpu_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_opcode;
  logic [AW-1:0]  in_rs0;
  logic [AW-1:0]  in_rs1;
  logic           in_use_rs1;
  logic [AW-1:0]  in_rd;
  logic           in_rd_we;
  logic [DW-1:0]  in_imm;

  logic [AW-1:0]  raddr0;
  logic [AW-1:0]  raddr1;
  logic [DW-1:0]  rdata0;
  logic [DW-1:0]  rdata1;

  logic           wb_we;
  logic [AW-1:0]  wb_waddr;
  logic [DW-1:0]  wb_wdata;

  logic           out_valid;
  logic           out_ready;
  logic [OPW-1:0] out_opcode;
  logic [DW-1:0]  out_op0;
  logic [DW-1:0]  out_op1;
  logic [AW-1:0]  out_rd;
  logic           out_rd_we;
  logic [DW-1:0]  out_imm;

  // The surrounding pipeline (decode, regfile, execute) is the master side.
  modport master (
    output in_valid, in_opcode, in_rs0, in_rs1, in_use_rs1, in_rd, in_rd_we, in_imm,
    output rdata0, rdata1, wb_we, wb_waddr, wb_wdata, out_ready,
    input  in_ready, raddr0, raddr1,
    input  out_valid, out_opcode, out_op0, out_op1, out_rd, out_rd_we, out_imm
  );

  modport slave (
    input  in_valid, in_opcode, in_rs0, in_rs1, in_use_rs1, in_rd, in_rd_we, in_imm,
    input  rdata0, rdata1, wb_we, wb_waddr, wb_wdata, out_ready,
    output in_ready, raddr0, raddr1,
    output out_valid, out_opcode, out_op0, out_op1, out_rd, out_rd_we, out_imm
  );

endinterface

// File: rtl/mini_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback,
// set wins when both target the same register in one cycle.
module mini_scoreboard
  import mini_cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_i,
  input  logic [AW-1:0] set_addr_i,
  input  logic          clr_i,
  input  logic [AW-1:0] clr_addr_i,
  input  logic [AW-1:0] rs0_addr_i,
  input  logic [AW-1:0] rs1_addr_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic          rs0_busy_o,
  output logic          rs1_busy_o,
  output logic          rd_busy_o
);

  logic [NUM_REGS-1:0] sb_q;
  logic [NUM_REGS-1:0] sb_d;

  // Clear is applied first so a same-register set overrides it.
  always_comb begin
    sb_d = sb_q;
    if (clr_i) sb_d[clr_addr_i] = 1'b0;
    if (set_i) sb_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_q <= '0;
    else        sb_q <= sb_d;
  end

  assign rs0_busy_o = sb_q[rs0_addr_i];
  assign rs1_busy_o = sb_q[rs1_addr_i];
  assign rd_busy_o  = sb_q[rd_addr_i];

endmodule

// File: rtl/mini_operand_fetch.sv
// Operand-fetch / issue stage: reads the regfile, tracks pending writes and stalls on hazards.
// Define MINI_OF_BYPASS_EN to forward same-cycle writeback data and relieve the matching hazard.
module mini_operand_fetch
  import mini_cpu_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  mini_operand_fetch_if.slave bus
);

  logic busy0, busy1, busyd;
  logic fwd0, fwd1, fwdd;
  logic hazard, accept;
  logic [DW-1:0] op0, op1;

  logic           out_valid_q, out_valid_d;
  logic [OPW-1:0] opcode_q, opcode_d;
  logic [DW-1:0]  op0_q, op0_d;
  logic [DW-1:0]  op1_q, op1_d;
  logic [AW-1:0]  rd_q, rd_d;
  logic           rd_we_q, rd_we_d;
  logic [DW-1:0]  imm_q, imm_d;

  mini_scoreboard u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_i      (accept && bus.in_rd_we),
    .set_addr_i (bus.in_rd),
    .clr_i      (bus.wb_we),
    .clr_addr_i (bus.wb_waddr),
    .rs0_addr_i (bus.in_rs0),
    .rs1_addr_i (bus.in_rs1),
    .rd_addr_i  (bus.in_rd),
    .rs0_busy_o (busy0),
    .rs1_busy_o (busy1),
    .rd_busy_o  (busyd)
  );

  assign bus.raddr0 = bus.in_rs0;
  assign bus.raddr1 = bus.in_rs1;

`ifdef MINI_OF_BYPASS_EN
  // The regfile only updates on the edge, so a writeback hitting a source this cycle
  // must be forwarded whether or not its pending bit is set.
  assign fwd0 = bus.wb_we && (bus.wb_waddr == bus.in_rs0);
  assign fwd1 = bus.wb_we && (bus.wb_waddr == bus.in_rs1);
  assign fwdd = bus.wb_we && (bus.wb_waddr == bus.in_rd);
`else
  assign fwd0 = 1'b0;
  assign fwd1 = 1'b0;
  assign fwdd = 1'b0;
`endif

  assign hazard = (busy0 && !fwd0)
               || (bus.in_use_rs1 && busy1 && !fwd1)
               || (bus.in_rd_we && busyd && !fwdd);

  assign op0 = fwd0 ? bus.wb_wdata : bus.rdata0;
  assign op1 = fwd1 ? bus.wb_wdata : bus.rdata1;

  assign bus.in_ready = (!out_valid_q || bus.out_ready) && !hazard;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    opcode_d    = opcode_q;
    op0_d       = op0_q;
    op1_d       = op1_q;
    rd_d        = rd_q;
    rd_we_d     = rd_we_q;
    imm_d       = imm_q;
    if (accept) begin
      out_valid_d = 1'b1;
      opcode_d    = bus.in_opcode;
      op0_d       = op0;
      op1_d       = op1;
      rd_d        = bus.in_rd;
      rd_we_d     = bus.in_rd_we;
      imm_d       = bus.in_imm;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      op0_q       <= '0;
      op1_q       <= '0;
      rd_q        <= '0;
      rd_we_q     <= 1'b0;
      imm_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      op0_q       <= op0_d;
      op1_q       <= op1_d;
      rd_q        <= rd_d;
      rd_we_q     <= rd_we_d;
      imm_q       <= imm_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_opcode = opcode_q;
  assign bus.out_op0    = op0_q;
  assign bus.out_op1    = op1_q;
  assign bus.out_rd     = rd_q;
  assign bus.out_rd_we  = rd_we_q;
  assign bus.out_imm    = imm_q;

endmodule

// File: tb/tb_mini_operand_fetch.sv
// Directed bench for mini_operand_fetch with a small regfile model on the read/write ports.
// Expectations follow MINI_OF_BYPASS_EN when it is defined for the build.
module tb_mini_operand_fetch;
  import mini_cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mini_operand_fetch_if bus ();

  mini_operand_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile model: combinational read, write on the edge from the writeback port.
  logic [DW-1:0] rf [NUM_REGS];
  always @(posedge clk) if (bus.wb_we) rf[bus.wb_waddr] <= bus.wb_wdata;
  assign bus.rdata0 = rf[bus.raddr0];
  assign bus.rdata1 = rf[bus.raddr1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_instr(input logic [OPW-1:0] opc, input logic [AW-1:0] rs0,
                             input logic [AW-1:0] rs1, input logic use1,
                             input logic [AW-1:0] rd, input logic rdwe, input logic [DW-1:0] imm);
    bus.in_valid   = 1'b1;
    bus.in_opcode  = opc;
    bus.in_rs0     = rs0;
    bus.in_rs1     = rs1;
    bus.in_use_rs1 = use1;
    bus.in_rd      = rd;
    bus.in_rd_we   = rdwe;
    bus.in_imm     = imm;
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wb_we    = 1'b1;
    bus.wb_waddr = a;
    bus.wb_wdata = d;
    tick();
    bus.wb_we    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_rs0 = '0; bus.in_rs1 = '0;
    bus.in_use_rs1 = 1'b0; bus.in_rd = '0; bus.in_rd_we = 1'b0; bus.in_imm = '0;
    bus.wb_we = 1'b0; bus.wb_waddr = '0; bus.wb_wdata = '0; bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_op0 !== 8'h00 || bus.out_op1 !== 8'h00 || bus.out_imm !== 8'h00) begin
      failures++; $display("[TB] FAIL reset_data got=%h/%h/%h exp=00/00/00", bus.out_op0, bus.out_op1, bus.out_imm); end
    checks++; if (dut.u_sb.sb_q !== 4'b0000) begin failures++; $display("[TB] FAIL reset_sb got=%b exp=0000", dut.u_sb.sb_q); end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_accept();
    write_reg(2'd0, 8'hF0);
    write_reg(2'd1, 8'h12);
    write_reg(2'd2, 8'h34);
    drive_instr(OP_ADD, 2'd1, 2'd2, 1'b1, 2'd3, 1'b1, 8'hA5);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL accept_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.raddr0 !== 2'd1 || bus.raddr1 !== 2'd2) begin
      failures++; $display("[TB] FAIL accept_raddr got=%0d/%0d exp=1/2", bus.raddr0, bus.raddr1); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL accept_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_op0 !== 8'h12 || bus.out_op1 !== 8'h34) begin
      failures++; $display("[TB] FAIL accept_ops got=%h/%h exp=12/34", bus.out_op0, bus.out_op1); end
    checks++; if (bus.out_imm !== 8'hA5 || bus.out_rd !== 2'd3 || bus.out_rd_we !== 1'b1 || bus.out_opcode !== OP_ADD) begin
      failures++; $display("[TB] FAIL accept_fields got=%h/%0d/%b/%h exp=a5/3/1/1", bus.out_imm, bus.out_rd, bus.out_rd_we, bus.out_opcode); end
    checks++; if (dut.u_sb.sb_q !== 4'b1000) begin failures++; $display("[TB] FAIL accept_sb got=%b exp=1000", dut.u_sb.sb_q); end
  endtask

  task automatic test_raw_stall();
    bus.out_ready = 1'b1;
    drive_instr(OP_MOV, 2'd3, 2'd0, 1'b0, 2'd0, 1'b0, 8'h11);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL raw_c0_ready got=%b exp=0", bus.in_ready); end
    tick();
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL raw_c1_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL consume_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_op0 !== 8'h12) begin failures++; $display("[TB] FAIL consume_hold got=%h exp=12", bus.out_op0); end
    tick();
    bus.wb_we = 1'b1; bus.wb_waddr = 2'd3; bus.wb_wdata = 8'h77;
    #1;
`ifdef MINI_OF_BYPASS_EN
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL raw_wb_ready got=%b exp=1", bus.in_ready); end
    tick();
    bus.wb_we = 1'b0;
`else
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL raw_wb_ready got=%b exp=0", bus.in_ready); end
    tick();
    bus.wb_we = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL raw_after_ready got=%b exp=1", bus.in_ready); end
    tick();
`endif
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_op0 !== 8'h77) begin
      failures++; $display("[TB] FAIL raw_op0 got=%b/%h exp=1/77", bus.out_valid, bus.out_op0); end
    checks++; if (dut.u_sb.sb_q !== 4'b0000) begin failures++; $display("[TB] FAIL raw_sb got=%b exp=0000", dut.u_sb.sb_q); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive_instr(OP_SUB, 2'd1, 2'd2, 1'b1, 2'd2, 1'b1, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready[%0d] got=%b exp=0", i, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_op0 !== 8'h77 || bus.out_imm !== 8'h11 || bus.out_opcode !== OP_MOV) begin
        failures++; $display("[TB] FAIL bp_stable[%0d] got=%b/%h/%h exp=1/77/11", i, bus.out_valid, bus.out_op0, bus.out_imm); end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_release_ready got=%b exp=1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_op0 !== 8'h12 || bus.out_op1 !== 8'h34 || bus.out_imm !== 8'h5A) begin
      failures++; $display("[TB] FAIL bp_next got=%b/%h/%h/%h exp=1/12/34/5a", bus.out_valid, bus.out_op0, bus.out_op1, bus.out_imm); end
    checks++; if (dut.u_sb.sb_q !== 4'b0100) begin failures++; $display("[TB] FAIL bp_sb got=%b exp=0100", dut.u_sb.sb_q); end
  endtask

  task automatic test_collision();
    bus.out_ready = 1'b1;
`ifndef MINI_OF_BYPASS_EN
    // Without forwarding the WAW stall blocks the collision, so clear r2 first.
    write_reg(2'd2, 8'h56);
    checks++; if (dut.u_sb.sb_q !== 4'b0000) begin failures++; $display("[TB] FAIL wb_clear_sb got=%b exp=0000", dut.u_sb.sb_q); end
`endif
    drive_instr(OP_AND, 2'd0, 2'd1, 1'b1, 2'd2, 1'b1, 8'h3C);
    bus.wb_we = 1'b1; bus.wb_waddr = 2'd2; bus.wb_wdata = 8'h99;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL coll_ready got=%b exp=1", bus.in_ready); end
    tick();
    bus.wb_we = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_op0 !== 8'hF0 || bus.out_op1 !== 8'h12 || bus.out_rd !== 2'd2) begin
      failures++; $display("[TB] FAIL coll_out got=%b/%h/%h/%0d exp=1/f0/12/2", bus.out_valid, bus.out_op0, bus.out_op1, bus.out_rd); end
    checks++; if (dut.u_sb.sb_q !== 4'b0100) begin failures++; $display("[TB] FAIL coll_sb got=%b exp=0100", dut.u_sb.sb_q); end
  endtask

  task automatic test_unused_rs1();
    bus.out_ready = 1'b1;
    drive_instr(OP_LDI, 2'd0, 2'd0, 1'b0, 2'd1, 1'b1, 8'h01);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL ldi_ready got=%b exp=1", bus.in_ready); end
    tick();
    drive_instr(OP_OR, 2'd0, 2'd1, 1'b1, 2'd0, 1'b0, 8'h02);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL rs1_hazard_ready got=%b exp=0", bus.in_ready); end
    bus.in_use_rs1 = 1'b0; bus.in_rd = 2'd2; bus.in_rd_we = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL waw_ready got=%b exp=0", bus.in_ready); end
    bus.in_rd_we = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL unused_rs1_ready got=%b exp=1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_op0 !== 8'hF0 || bus.out_op1 !== 8'h12 || bus.out_rd_we !== 1'b0) begin
      failures++; $display("[TB] FAIL unused_rs1_out got=%b/%h/%h/%b exp=1/f0/12/0", bus.out_valid, bus.out_op0, bus.out_op1, bus.out_rd_we); end
    checks++; if (dut.u_sb.sb_q !== 4'b0110) begin failures++; $display("[TB] FAIL unused_rs1_sb got=%b exp=0110", dut.u_sb.sb_q); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    drive_instr(OP_XOR, 2'd0, 2'd0, 1'b0, 2'd3, 1'b1, 8'h07);
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    write_reg(2'd2, 8'h22);
    checks++; if (dut.u_sb.sb_q !== 4'b1010 || bus.out_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL pre_reset got=%b/%b exp=1010/1", dut.u_sb.sb_q, bus.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (dut.u_sb.sb_q !== 4'b0000) begin failures++; $display("[TB] FAIL midreset_sb got=%b exp=0000", dut.u_sb.sb_q); end
    checks++; if (bus.out_op0 !== 8'h00 || bus.out_imm !== 8'h00) begin
      failures++; $display("[TB] FAIL midreset_data got=%h/%h exp=00/00", bus.out_op0, bus.out_imm); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_valid got=%b exp=0", bus.out_valid); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_accept();
    test_raw_stall();
    test_backpressure();
    test_collision();
    test_unused_rs1();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
